// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bit-timing constants for the I2C master
package i2c_pkg;
    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_START    = 5'd1,
        S_DEV      = 5'd2,
        S_RW       = 5'd3,
        S_ACK_DEV  = 5'd4,
        S_MEM      = 5'd5,
        S_ACK_MEM  = 5'd6,
        S_WDATA    = 5'd7,
        S_ACK_DATA = 5'd8,
        S_RDATA    = 5'd9,
        S_MACK     = 5'd10,
        S_STOP     = 5'd11
    } state_t;
    localparam int CLK_DIV_DEF = 8;
    localparam int DEV_BITS    = 7;
    localparam int SAMPLE      = 2;
    localparam int CHANGE      = 6;
endpackage

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: free-running bit-time divider; SCL high for the first half of each period
module i2c_scl_gen #(
    parameter int CLK_DIV = 8,
    parameter int CW      = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [CW-1:0] o_cnt,
    output logic          o_scl
);
    logic [CW-1:0] r_cnt;

    // wrap the counter at CLK_DIV-1 so every SCL period is exactly CLK_DIV clocks
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else r_cnt <= (r_cnt == CW'(CLK_DIV - 1)) ? '0 : r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_scl = r_cnt < CW'(CLK_DIV / 2);
endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C read/write master with open-drain SDA and free-running SCL
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk8x,
    input  logic       reset,
    input  logic       ce,
    input  logic       rden,
    input  logic       wren,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       error,
    output logic       SCL,
    inout  wire        SDA,
    output logic [4:0] state,
    output logic [7:0] test
);
    localparam int CW = $clog2(CLK_DIV);
    // SDA is registered, so drive actions fire one count before the edge they must appear on
    localparam logic [CW-1:0] C_EDGE = CW'(SAMPLE * CLK_DIV / 8 - 1);
    localparam logic [CW-1:0] C_SMP  = CW'(SAMPLE * CLK_DIV / 8);
    localparam logic [CW-1:0] C_CHG  = CW'(CHANGE * CLK_DIV / 8 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] w_cnt;
    logic          w_edge, w_smp, w_chg, w_last, w_sda;
    state_t        r_state;
    logic          r_low, r_rd, r_error;
    logic [7:0]    r_addr, r_wdata, r_sh, r_rdata;
    logic [2:0]    r_bit;

    i2c_scl_gen #(.CLK_DIV(CLK_DIV), .CW(CW)) u_scl (
        .i_clk (clk8x),
        .i_rst (reset),
        .o_cnt (w_cnt),
        .o_scl (SCL)
    );

    assign w_edge = w_cnt == C_EDGE;
    assign w_smp  = w_cnt == C_SMP;
    assign w_chg  = w_cnt == C_CHG;
    assign w_last = w_cnt == C_LAST;
    assign w_sda  = SDA;
    assign SDA    = r_low ? 1'b0 : 1'bz;
    assign rdata  = r_rdata;
    assign error  = r_error;
    assign state  = r_state;
    assign test   = r_sh;

    // protocol sequencer: slot transitions at the change point, line sampling at the sample point
    always_ff @(posedge clk8x) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_low   <= 1'b0;
            r_rd    <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sh    <= '0;
            r_rdata <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_low <= 1'b0;
                    if (w_last && ce && (rden || wren)) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_rd    <= rden;
                        r_error <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_edge) r_low <= 1'b1;
                    if (w_chg) begin
                        r_sh    <= {5'b0, r_addr[7:6], r_rd};
                        r_low   <= 1'b1;
                        r_bit   <= 3'(DEV_BITS - 1);
                        r_state <= S_DEV;
                    end
                end
                S_DEV, S_MEM, S_WDATA: begin
                    if (w_chg) begin
                        r_sh  <= {r_sh[6:0], 1'b0};
                        r_low <= (r_bit == 3'd0 && r_state != S_DEV) ? 1'b0 : ~r_sh[6];
                        r_bit <= r_bit - 1'b1;
                        if (r_bit == 3'd0)
                            r_state <= r_state == S_DEV ? S_RW : r_state == S_MEM ? S_ACK_MEM : S_ACK_DATA;
                    end
                end
                S_RW: begin
                    if (w_chg) begin
                        r_low   <= 1'b0;
                        r_state <= S_ACK_DEV;
                    end
                end
                S_ACK_DEV, S_ACK_MEM, S_ACK_DATA: begin
                    if (w_smp && w_sda) r_error <= 1'b1;
                    if (w_chg) begin
                        if (r_error || r_state == S_ACK_DATA) begin
                            r_low   <= 1'b1;
                            r_state <= S_STOP;
                        end else if (r_state == S_ACK_DEV) begin
                            r_sh    <= {2'b00, r_addr[5:0]};
                            r_low   <= 1'b1;
                            r_bit   <= 3'd7;
                            r_state <= S_MEM;
                        end else if (r_rd) begin
                            r_bit   <= 3'd7;
                            r_state <= S_RDATA;
                        end else begin
                            r_sh    <= r_wdata;
                            r_low   <= ~r_wdata[7];
                            r_bit   <= 3'd7;
                            r_state <= S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_smp) begin
                        r_sh <= {r_sh[6:0], w_sda};
                        if (r_bit == 3'd0) r_rdata <= {r_sh[6:0], w_sda};
                    end
                    if (w_chg) begin
                        r_bit <= r_bit - 1'b1;
                        if (r_bit == 3'd0) begin
                            r_low   <= 1'b1;
                            r_state <= S_MACK;
                        end
                    end
                end
                S_MACK: begin
                    if (w_chg) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_edge) begin
                        r_low   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized frames against a bit-level slave and frame-level reference model
module tb_i2c_master;
    typedef struct {
        logic [31:0] bits;
        int          len;
        logic [7:0]  rdata;
        logic        err;
    } exp_t;

    logic       clk8x = 0, reset = 1, ce = 0, rden = 0, wren = 0;
    logic [7:0] addr = 0, wdata = 0;
    logic [7:0] rdata, test;
    logic       error, SCL;
    logic [4:0] state;
    wire        SDA;
    logic       slv_low = 0;
    int         slv_nack = 99;
    logic [7:0] slv_data = 0;
    logic [7:0] m_rdata = 0;
    exp_t       sb[$];
    int         n_cmp = 0, n_err = 0, done = 0;

    logic        ps = 1, pd = 1, s, d, inf = 0, rd8 = 0;
    int          hi = 0, p = 0, n = 0, hold = 0, nx;
    logic [31:0] cap = 0;
    exp_t        e;

    pullup (SDA);
    assign SDA = slv_low ? 1'b0 : 1'bz;

    i2c_master dut (
        .clk8x (clk8x),
        .reset (reset),
        .ce    (ce),
        .rden  (rden),
        .wren  (wren),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .error (error),
        .SCL   (SCL),
        .SDA   (SDA),
        .state (state),
        .test  (test)
    );

    always #5 clk8x = ~clk8x;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endfunction

    function automatic logic line();
        return (SDA === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    // bus monitor and slave: decodes START/STOP/bits from the wires, answers ACKs and read data
    initial begin
        forever begin
            @(negedge clk8x);
            s = SCL;
            d = line();
            if (reset || hold > 0) begin
                hold = reset ? 2 : hold - 1;
                inf = 0;
                slv_low = 0;
            end else begin
                if (s && !ps) begin
                    hi = 0;
                    if (inf) p++;
                end else if (s) hi++;
                if (s && ps && d != pd) begin
                    if (!d && !inf) begin
                        chk("start_delay", hi, 2);
                        inf = 1; p = 0; n = 0; cap = 0; rd8 = 0;
                    end else if (d && inf) begin
                        chk("stop_delay", hi, 2);
                        inf = 0;
                        slv_low = 0;
                        if (sb.size() == 0) begin
                            n_cmp++; n_err++;
                            $display("FAIL unexpected_frame: got %0d bits want none", n - 1);
                        end else begin
                            e = sb.pop_front();
                            chk("frame_len", n - 1, e.len);
                            chk("frame_bits", cap >> 1, e.bits);
                            chk("rdata", rdata, e.rdata);
                            chk("error", error, e.err);
                        end
                        done++;
                    end else begin
                        n_cmp++; n_err++;
                        $display("FAIL sda_edge_scl_high: got %0b->%0b at hi=%0d want stable", pd, d, hi);
                    end
                end
                if (inf && s && hi == 1 && p >= 1) begin
                    cap = {cap[30:0], d};
                    n++;
                    if (p == 8) rd8 = d;
                end
                if (inf && !s && ps) begin
                    nx = p + 1;
                    if (nx > 27 || nx > slv_nack) slv_low = 0;
                    else if (nx == 9 || nx == 18 || (nx == 27 && !rd8)) slv_low = nx != slv_nack;
                    else if (rd8 && nx >= 19 && nx <= 26) slv_low = !slv_data[26 - nx];
                    else slv_low = 0;
                end
            end
            ps = s;
            pd = d;
        end
    end

    task automatic txn(input logic rd_i, input logic wr_i, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] sd, input int nk, input bit push);
        logic [26:0] f;
        exp_t        x;
        int          k, d0;
        f = {5'b0, a[7:6], rd_i, 1'b0, 2'b00, a[5:0], 1'b0, rd_i ? sd : wd, 1'b0};
        x.len = (nk == 99) ? 27 : nk;
        x.bits = 32'(f >> (27 - x.len)) | ((nk == 99) ? 32'd0 : 32'd1);
        x.err = nk != 99;
        if (rd_i && nk == 99) m_rdata = sd;
        x.rdata = m_rdata;
        slv_nack = nk;
        slv_data = sd;
        d0 = done;
        if (push) sb.push_back(x);
        ce = 1; rden = rd_i; wren = wr_i; addr = a; wdata = wd;
        k = 0;
        while (state == 5'd0 && k < 40) begin
            @(posedge clk8x); #1;
            k++;
        end
        if (state == 5'd0) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got state 0 want busy");
        end
        if (push) begin
            repeat (60) begin
                @(posedge clk8x); #1;
                ce = 1'($urandom); rden = 1'($urandom); wren = 1'($urandom);
                addr = 8'($urandom); wdata = 8'($urandom);
            end
        end
        ce = 0; rden = 0; wren = 0;
        if (push) begin
            k = 0;
            while (done == d0 && k < 400) begin
                @(posedge clk8x); #1;
                k++;
            end
            if (done == d0) begin
                n_cmp++; n_err++;
                $display("FAIL frame_timeout: got no STOP want STOP");
            end
            repeat (3) @(posedge clk8x);
            #1;
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_state", state, 0);
        chk("rst_scl", SCL, 1);
        chk("rst_sda", line(), 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_error", error, 0);
        chk("rst_test", test, 0);
    endtask

    // stimulus: directed frames, randomized frames, then a reset in the middle of MEM
    initial begin
        int k, r;
        logic b, bo, rd;
        repeat (4) @(posedge clk8x);
        #1;
        chk_reset_state();
        reset = 0;
        txn(1, 0, 8'h41, 8'h00, 8'hA5, 99, 1);
        txn(0, 1, 8'h42, 8'h7F, 8'h00, 99, 1);
        txn(1, 0, 8'h41, 8'h00, 8'h3C, 9, 1);
        txn(1, 1, 8'h41, 8'h55, 8'h5A, 99, 1);
        repeat (14) begin
            b = 1'($urandom);
            bo = ($urandom % 4) == 0;
            rd = b | bo;
            r = int'($urandom % 4);
            txn(rd, !b | bo, 8'($urandom), 8'($urandom), 8'($urandom),
                r == 0 ? 9 : r == 1 ? 18 : (r == 2 && !rd) ? 27 : 99, 1);
        end
        txn(1, 0, 8'hC3, 8'h00, 8'hFF, 99, 0);
        k = 0;
        while (state != 5'd5 && k < 400) begin
            @(posedge clk8x); #1;
            k++;
        end
        chk("reach_mem", state, 5);
        repeat ($urandom_range(0, 30)) @(posedge clk8x);
        #1;
        reset = 1;
        @(posedge clk8x); #1;
        chk_reset_state();
        reset = 0;
        m_rdata = 0;
        txn(1, 0, 8'h41, 8'h00, 8'h96, 99, 1);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 8: clk8x cycles per SCL period; must be even and >= 8.
REQ-002 clk8x  in  1  sole clock, 8x SCL rate; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ce  in  1  chip enable from APB side; a request is valid only when ce=1.
REQ-005 rden  in  1  read request.
REQ-006 wren  in  1  write request.
REQ-007 addr  in  8  [7:6] device id, [5:0] memory address.
REQ-008 wdata  in  8  write data byte.
REQ-009 rdata  out  8  byte read from slave; held until next read completes.
REQ-010 error  out  1  slave NACK seen in current/last transfer.
REQ-011 SCL  out  1  I2C clock, free-running.
REQ-012 SDA  inout  1  open-drain: drives 0 or Z; sampled Z/1 reads as 1.
REQ-013 state  out  5  current FSM state encoding, debug.
REQ-014 test  out  8  debug: shift register contents of the byte in flight.

Function
REQ-015 Divider counter cnt 0..7 SHALL run continuously; SCL=1 for cnt 0-3, 0 for cnt 4-7 (SCL posedge at cnt=0, negedge at cnt=4).
REQ-016 Bit timing: SDA changes only at cnt=6 (mid SCL-low); SDA sampled at cnt=2 (mid SCL-high).
REQ-017 States: IDLE=0, START=1, DEV=2, RW=3, ACK_DEV=4, MEM=5, ACK_MEM=6, WDATA=7, ACK_DATA=8, RDATA=9, MACK=10, STOP=11.
REQ-018 IDLE: SDA released; at cnt=7 with ce=1 and rden|wren, latch addr, wdata, op (rden wins if both) and clear error -> START.
REQ-019 START: SDA pulled low at cnt=2 (SCL high), i.e. 2 clk8x after SCL posedge.
REQ-020 DEV: send 7 bits {5'b0, addr[7:6]} MSB first, one per SCL period.
REQ-021 RW: send 1 for read, 0 for write.
REQ-022 ACK_DEV/ACK_MEM/ACK_DATA: SDA released; sample at cnt=2; 0 = ACK continue; 1 = NACK -> error=1 and go to STOP.
REQ-023 MEM: send {2'b00, addr[5:0]} MSB first; then ACK_MEM -> WDATA (write) or RDATA (read).
REQ-024 WDATA: send latched wdata MSB first -> ACK_DATA -> STOP.
REQ-025 RDATA: SDA released, sample 8 bits MSB first; on 8th sample load rdata -> MACK.
REQ-026 MACK: master drives SDA=0 for one bit period -> STOP.
REQ-027 STOP: SDA low during SCL low, released at cnt=2 (SCL high) -> IDLE; new request accepted from next cnt=7.
REQ-028 One transaction = one byte; requests while not IDLE are ignored (no queuing).
REQ-029 Changes of addr/wdata/rden/wren during a transfer SHALL NOT affect it.
REQ-030 Total frame: START + 9 + 9 + 9 SCL periods + STOP.

Reset
REQ-031 reset (sampled on clk8x posedge) SHALL force cnt=0, state=IDLE, SDA released, SCL=1, rdata=0, error=0, test=0, any time including mid-transfer.

Structure
REQ-032 Package i2c_pkg: state enum (5-bit), CLK_DIV default, DEV_BITS=7, bit-time cnt constants (SAMPLE=2, CHANGE=6).
REQ-033 One sub-module i2c_scl_gen: divider producing cnt and SCL; FSM and shift registers in i2c_master.

Verification
REQ-034 Read: ce=1, rden=1, addr=8'h41, slave ACKs, returns 8'hA5 -> SDA bits 0000001,1 / 00000001 / MACK 0; rdata=8'hA5, error=0.
REQ-035 Write: ce=1, wren=1, addr=8'h42, wdata=8'h7F, slave ACKs all -> SDA bits 0000001,0 / 00000010 / 01111111; STOP; error=0.
REQ-036 Device NACK: slave leaves SDA high at ACK_DEV -> error=1, STOP follows immediately, rdata unchanged.
REQ-037 Timing: START SDA fall and STOP SDA rise each exactly 2 clk8x after SCL posedge; data SDA edges only while SCL=0.
REQ-038 Reset asserted mid MEM phase -> next clk8x edge state=0, SDA released, SCL=1; new read completes normally.
REQ-039 rden=wren=1, addr=8'h41 -> read transaction (RW bit 1).
